// File: rtl/tcam_search_ctrl.sv
// -----------------------------------------------------------------------------
// tcam_search_ctrl
//
// Register-based TCAM-style exact-match search controller. It holds MAX_RULE
// rule words of KEY_LEN bits, each with a valid bit. A search compares the
// latched key against every valid rule in parallel and reports the lowest
// matching index. Rule updates and searches share one small FSM:
// IDLE -> CMP -> ENC -> IDLE for a search and IDLE -> WR -> IDLE for an update.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   srch_valid/ready  search handshake, srch_key sampled on handshake
//   wr_valid/ready    update handshake, wr_idx/wr_rule/wr_set sampled on it
//   res_valid         one-cycle result strobe (ENC state)
//   res_hit/res_idx   result; held until the next result
//   rule_cnt          number of valid entries
//   busy              FSM is not IDLE
// -----------------------------------------------------------------------------
module tcam_search_ctrl #(
    parameter int MAX_RULE = 64,
    parameter int KEY_LEN  = 32,
    parameter int IDX_W    = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               srch_valid,
    output logic               srch_ready,
    input  logic [KEY_LEN-1:0] srch_key,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [KEY_LEN-1:0] wr_rule,
    input  logic               wr_set,
    output logic               res_valid,
    output logic               res_hit,
    output logic [IDX_W-1:0]   res_idx,
    output logic [IDX_W:0]     rule_cnt,
    output logic               busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CMP  = 2'd1;
    localparam logic [1:0] ENC  = 2'd2;
    localparam logic [1:0] WR   = 2'd3;

    localparam logic [IDX_W:0] CNT_ONE = {{IDX_W{1'b0}}, 1'b1};

    logic [1:0]          state_r;
    logic [1:0]          state_nxt_s;
    logic [KEY_LEN-1:0]  key_r;
    logic [KEY_LEN-1:0]  rule_r [MAX_RULE];
    logic [MAX_RULE-1:0] valid_r;
    logic [MAX_RULE-1:0] match_s;
    logic [MAX_RULE-1:0] match_r;
    logic [IDX_W:0]      rule_cnt_r;
    logic                hit_hold_r;
    logic [IDX_W-1:0]    idx_hold_r;
    logic                srch_hs_s;
    logic                wr_hs_s;
    logic                enc_s;
    logic                enc_hit_s;
    logic [IDX_W-1:0]    enc_idx_s;

    // Lowest set bit of a match vector; zero when the vector is empty.
    function automatic logic [IDX_W-1:0] lowest_idx(input logic [MAX_RULE-1:0] vec);
        logic [IDX_W-1:0] idx;
        idx = {IDX_W{1'b0}};
        for (int i = MAX_RULE - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // A pending write blocks the search handshake so the write always wins.
    assign wr_ready   = (state_r == IDLE);
    assign srch_ready = (state_r == IDLE) && !wr_valid;
    assign wr_hs_s    = wr_valid && wr_ready;
    assign srch_hs_s  = srch_valid && srch_ready;
    assign busy       = (state_r != IDLE);

    // During ENC the result comes straight from the registered match vector;
    // afterwards the hold registers keep it stable until the next ENC.
    assign enc_s     = (state_r == ENC);
    assign enc_hit_s = |match_r;
    assign enc_idx_s = lowest_idx(match_r);
    assign res_valid = enc_s && !rst;
    assign res_hit   = enc_s ? enc_hit_s : hit_hold_r;
    assign res_idx   = enc_s ? enc_idx_s : idx_hold_r;
    assign rule_cnt  = rule_cnt_r;

    // Parallel exact-match compare; invalid entries never match.
    always_comb begin
        match_s = {MAX_RULE{1'b0}};
        for (int i = 0; i < MAX_RULE; i++) begin
            match_s[i] = valid_r[i] && (rule_r[i] == key_r);
        end
    end

    // FSM next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (wr_hs_s) begin
                    state_nxt_s = WR;
                end else if (srch_hs_s) begin
                    state_nxt_s = CMP;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CMP:     state_nxt_s = ENC;
            ENC:     state_nxt_s = IDLE;
            WR:      state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Control state: FSM, valid bits, entry count, match vector, result hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            valid_r    <= {MAX_RULE{1'b0}};
            rule_cnt_r <= {(IDX_W + 1){1'b0}};
            match_r    <= {MAX_RULE{1'b0}};
            hit_hold_r <= 1'b0;
            idx_hold_r <= {IDX_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (wr_hs_s) begin
                valid_r[wr_idx] <= wr_set;
                // Count only real 0->1 / 1->0 transitions of the valid bit.
                if (wr_set && !valid_r[wr_idx]) begin
                    rule_cnt_r <= rule_cnt_r + CNT_ONE;
                end else if (!wr_set && valid_r[wr_idx]) begin
                    rule_cnt_r <= rule_cnt_r - CNT_ONE;
                end
            end
            if (state_r == CMP) begin
                match_r <= match_s;
            end
            if (enc_s) begin
                hit_hold_r <= enc_hit_s;
                idx_hold_r <= enc_idx_s;
            end
        end
    end

    // Datapath storage: search key and rule words (contents need no reset).
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (srch_hs_s) begin
                key_r <= srch_key;
            end
            if (wr_hs_s && wr_set) begin
                rule_r[wr_idx] <= wr_rule;
            end
        end
    end

endmodule

// File: tb/tb_tcam_search_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for tcam_search_ctrl. Stimulus tasks drive the DUT shortly after
// each rising edge and push the expected result of every accepted search into
// a queue; a monitor samples on the falling edge, pops and compares whenever
// res_valid is seen, and tracks rule_cnt and the held result between strobes.
// The reference model is a plain array of rules/valid flags searched linearly.
// -----------------------------------------------------------------------------
module tb_tcam_search_ctrl;

    localparam int MAX_RULE = 64;
    localparam int KEY_LEN  = 32;
    localparam int IDX_W    = 6;

    logic               clk;
    logic               rst;
    logic               srch_valid;
    logic               srch_ready;
    logic [KEY_LEN-1:0] srch_key;
    logic               wr_valid;
    logic               wr_ready;
    logic [IDX_W-1:0]   wr_idx;
    logic [KEY_LEN-1:0] wr_rule;
    logic               wr_set;
    logic               res_valid;
    logic               res_hit;
    logic [IDX_W-1:0]   res_idx;
    logic [IDX_W:0]     rule_cnt;
    logic               busy;

    tcam_search_ctrl #(.MAX_RULE(MAX_RULE), .KEY_LEN(KEY_LEN), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst),
        .srch_valid(srch_valid), .srch_ready(srch_ready), .srch_key(srch_key),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_idx(wr_idx),
        .wr_rule(wr_rule), .wr_set(wr_set),
        .res_valid(res_valid), .res_hit(res_hit), .res_idx(res_idx),
        .rule_cnt(rule_cnt), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit hit;
        int idx;
        int cnt;
        int cyc;
    } exp_t;

    int          errors = 0;
    int          checks = 0;
    int          cyc    = 0;
    exp_t        sb[$];
    logic [31:0] m_rule [MAX_RULE];
    bit          m_valid[MAX_RULE];
    int          m_cnt;
    bit          mon_en = 1'b0;
    bit          last_hit;
    int          last_idx;
    exp_t        mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < MAX_RULE; i++) m_valid[i] = 1'b0;
        m_cnt = 0;
    endfunction

    function automatic void model_write(int idx, logic [31:0] rule, bit set);
        if (set) begin
            if (!m_valid[idx]) m_cnt++;
            m_valid[idx] = 1'b1;
            m_rule[idx]  = rule;
        end else begin
            if (m_valid[idx]) m_cnt--;
            m_valid[idx] = 1'b0;
        end
    endfunction

    function automatic exp_t model_search(logic [31:0] key);
        exp_t e;
        e.hit = 1'b0;
        e.idx = 0;
        e.cnt = m_cnt;
        e.cyc = 0;
        for (int i = 0; i < MAX_RULE; i++) begin
            if (m_valid[i] && m_rule[i] == key) begin
                e.hit = 1'b1;
                e.idx = i;
                break;
            end
        end
        return e;
    endfunction

    // Monitor: result scoreboard, held-result and entry-count tracking.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rst) begin
                last_hit = 1'b0;
                last_idx = 0;
            end else begin
                if (res_valid) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_res_valid", 1, 0);
                    end else begin
                        mon_e = sb.pop_front();
                        chk("res_hit", res_hit, mon_e.hit);
                        chk("res_idx", res_idx, mon_e.idx);
                        chk("res_rule_cnt", rule_cnt, mon_e.cnt);
                        chk("latency", cyc - mon_e.cyc, 2);
                        last_hit = mon_e.hit;
                        last_idx = mon_e.idx;
                    end
                end else begin
                    chk("hold_hit", res_hit, last_hit);
                    chk("hold_idx", res_idx, last_idx);
                end
                chk("rule_cnt", rule_cnt, m_cnt);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // All operation tasks start and end at posedge+2 of an IDLE cycle.
    task automatic do_write(input int idx, input logic [31:0] rule, input bit set);
        wr_valid = 1'b1; wr_idx = IDX_W'(idx); wr_rule = rule; wr_set = set;
        @(negedge clk);
        chk("wr_ready_idle", wr_ready, 1);
        chk("busy_idle", busy, 0);
        @(posedge clk);
        model_write(idx, rule, set);
        #2;
        wr_valid = 1'b0; wr_rule = $urandom;
        @(negedge clk);
        chk("busy_wr", busy, 1);
        chk("wr_ready_wr", wr_ready, 0);
        tick();
    endtask

    task automatic do_search(input logic [31:0] key);
        exp_t e;
        int   hs;
        srch_valid = 1'b1; srch_key = key;
        @(negedge clk);
        chk("srch_ready_idle", srch_ready, 1);
        hs = cyc;
        @(posedge clk);
        e = model_search(key);
        e.cyc = hs;
        sb.push_back(e);
        #2;
        // Disturb the non-handshake inputs while busy; they must be ignored.
        srch_valid = 1'b0; srch_key = $urandom;
        wr_valid = 1'($urandom_range(0, 1)); wr_idx = 6'($urandom); wr_set = 1'b1; wr_rule = key;
        @(negedge clk);
        chk("busy_cmp", busy, 1);
        chk("wr_ready_cmp", wr_ready, 0);
        chk("srch_ready_cmp", srch_ready, 0);
        tick();
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic write_and_search(input int idx, input logic [31:0] rule);
        exp_t e;
        int   hs;
        wr_valid = 1'b1; wr_idx = IDX_W'(idx); wr_rule = rule; wr_set = 1'b1;
        srch_valid = 1'b1; srch_key = rule;
        @(negedge clk);
        chk("both_wr_ready", wr_ready, 1);
        chk("both_srch_ready", srch_ready, 0);
        @(posedge clk);
        model_write(idx, rule, 1'b1);
        #2;
        wr_valid = 1'b0;
        @(negedge clk);
        chk("both_srch_ready_wr", srch_ready, 0);
        tick();
        @(negedge clk);
        chk("both_srch_ready_late", srch_ready, 1);
        hs = cyc;
        @(posedge clk);
        e = model_search(rule);
        e.cyc = hs;
        sb.push_back(e);
        #2;
        srch_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic search_abort(input logic [31:0] key);
        srch_valid = 1'b1; srch_key = key;
        @(negedge clk);
        chk("abort_srch_ready", srch_ready, 1);
        @(posedge clk);
        #2;
        srch_valid = 1'b0;
        rst = 1'b1;
        model_clear();
        @(negedge clk);
        chk("abort_res_valid_in_rst", res_valid, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("abort_srch_ready_after", srch_ready, 1);
        chk("abort_wr_ready_after", wr_ready, 1);
        chk("abort_busy", busy, 0);
        chk("abort_res_valid", res_valid, 0);
        chk("abort_rule_cnt", rule_cnt, 0);
        chk("abort_res_hit", res_hit, 0);
        tick();
        tick();
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pool_key;
        int          op;
        rst = 1'b1;
        srch_valid = 1'b0; srch_key = 32'h0;
        wr_valid = 1'b0; wr_idx = 6'd0; wr_rule = 32'h0; wr_set = 1'b0;
        model_clear();
        last_hit = 1'b0;
        last_idx = 0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        chk("reset_srch_ready", srch_ready, 1);
        chk("reset_wr_ready", wr_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_res_valid", res_valid, 0);
        chk("reset_res_hit", res_hit, 0);
        chk("reset_res_idx", res_idx, 0);
        chk("reset_rule_cnt", rule_cnt, 0);
        tick();

        // Empty table search.
        do_search(32'h0000_0000);
        // Duplicate rules: lowest index wins.
        do_write(5, 32'hC0A8_0001, 1'b1);
        do_write(9, 32'hC0A8_0001, 1'b1);
        do_search(32'hC0A8_0001);
        // Invalidate, then invalidate an already-invalid entry.
        do_write(5, 32'h0, 1'b0);
        do_search(32'hC0A8_0001);
        do_write(5, 32'h0, 1'b0);
        // Simultaneous write and search request.
        write_and_search(2, 32'h1234_5678);
        // Top index, then fill every entry.
        do_write(63, 32'hFFFF_FFFF, 1'b1);
        do_search(32'hFFFF_FFFF);
        for (int i = 0; i < MAX_RULE; i++) do_write(i, 32'hA500_0000 | 32'(i), 1'b1);
        @(negedge clk);
        chk("full_rule_cnt", rule_cnt, 64);
        tick();
        do_search(32'hA500_0020);
        do_search(32'hA500_003F);
        // Rewrite a valid entry: count unchanged.
        do_write(10, 32'hA500_000A, 1'b1);

        // Randomized mix over a small key pool so hits are frequent.
        for (int n = 0; n < 300; n++) begin
            op = $urandom_range(0, 3);
            pool_key = 32'hC0A8_0000 + 32'($urandom_range(0, 3));
            case (op)
                0: do_write($urandom_range(0, 15), pool_key, 1'b1);
                1: do_write($urandom_range(0, 15), 32'($urandom), 1'b0);
                2: do_search(pool_key);
                default: tick();
            endcase
        end

        // Reset while a search is in CMP.
        do_write(7, 32'hDEAD_BEEF, 1'b1);
        search_abort(32'hDEAD_BEEF);
        do_search(32'hDEAD_BEEF);

        repeat (4) tick();
        chk("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tcam_search_ctrl.md
TCAM_SEARCH_CTRL -- requirements
Module: tcam_search_ctrl

Interface
REQ-001 SHALL have parameter MAX_RULE, default 64, number of rule entries.
REQ-002 SHALL have parameter KEY_LEN, default 32, search key and rule width in bits.
REQ-003 SHALL have parameter IDX_W, default 6, rule index width; MAX_RULE = 2**IDX_W.
REQ-004 clk  input  1  clock; all state on posedge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 srch_valid  input  1  search request.
REQ-007 srch_ready  output  1  search accepted when srch_valid && srch_ready.
REQ-008 srch_key  input  KEY_LEN  key to match, sampled at search handshake.
REQ-009 wr_valid  input  1  rule update request.
REQ-010 wr_ready  output  1  update accepted when wr_valid && wr_ready.
REQ-011 wr_idx  input  IDX_W  entry to update.
REQ-012 wr_rule  input  KEY_LEN  rule value to store.
REQ-013 wr_set  input  1  1 = mark entry valid with wr_rule; 0 = invalidate entry (wr_rule ignored).
REQ-014 res_valid  output  1  one-cycle result strobe; no backpressure.
REQ-015 res_hit  output  1  at least one valid entry matched.
REQ-016 res_idx  output  IDX_W  lowest matching index; 0 when no hit.
REQ-017 rule_cnt  output  IDX_W+1  number of currently valid entries.
REQ-018 busy  output  1  high whenever FSM is not IDLE.

Function
REQ-019 SHALL hold MAX_RULE x KEY_LEN rule registers plus MAX_RULE valid bits.
REQ-020 FSM states SHALL be IDLE, CMP, ENC, WR.
REQ-021 srch_ready and wr_ready SHALL be combinationally asserted only in IDLE; wr_ready = IDLE; srch_ready = IDLE && !wr_valid.
REQ-022 Simultaneous wr_valid and srch_valid in IDLE: write accepted, search stalls (no handshake) until a later IDLE cycle.
REQ-023 Search handshake in cycle T: key latched, IDLE->CMP.
REQ-024 CMP (T+1): per-entry match vector registered, bit i = valid[i] && (rule[i] == key), full KEY_LEN exact equality; CMP->ENC.
REQ-025 ENC (T+2): res_valid=1, res_hit = OR of match vector, res_idx = lowest set bit index (0 if none); ENC->IDLE.
REQ-026 Search latency SHALL be exactly 2 cycles handshake-to-res_valid; back-to-back searches sustain one result per 3 cycles.
REQ-027 res_hit and res_idx SHALL hold their values until the next ENC; res_valid SHALL be 0 outside ENC.
REQ-028 Write handshake in cycle T: rule[wr_idx] and valid[wr_idx] updated at end of T; IDLE->WR; WR->IDLE unconditionally at T+1.
REQ-029 A search accepted after a write SHALL observe the written value.
REQ-030 rule_cnt SHALL increment when a set write changes valid 0->1, decrement on invalidate 1->0, else unchanged (rewriting a valid entry or invalidating an invalid entry leaves count unchanged).
REQ-031 rule_cnt SHALL never exceed MAX_RULE nor underflow below 0.
REQ-032 Invalid entries SHALL never match, even if stored rule equals key.
REQ-033 Inputs other than the handshake-qualified ones SHALL be ignored outside IDLE.

Reset
REQ-034 On rst: FSM=IDLE, all valid bits=0, rule_cnt=0, res_valid=0, res_hit=0, res_idx=0, match vector=0; rule data value need not be cleared.
REQ-035 rst asserted in CMP or ENC SHALL abort the search with no res_valid pulse; rst dominates any concurrent handshake.
REQ-036 srch_ready and wr_ready SHALL be 1 the first cycle after rst deasserts.

Verification
REQ-037 After reset, search key 0x00000000 -> res_valid at T+2, res_hit=0, res_idx=0, rule_cnt=0.
REQ-038 Write idx 5 = 0xC0A80001 and idx 9 = 0xC0A80001, search 0xC0A80001 -> res_hit=1, res_idx=5, rule_cnt=2.
REQ-039 Invalidate idx 5, search 0xC0A80001 -> res_idx=9, rule_cnt=1; invalidate idx 5 again -> rule_cnt stays 1.
REQ-040 wr_valid and srch_valid both high in IDLE -> write handshake only, srch_ready=0 that cycle, search accepted two cycles later, result reflects new rule.
REQ-041 Write idx 63 = 0xFFFFFFFF, search 0xFFFFFFFF -> res_idx=63; fill all 64 entries -> rule_cnt=64.
REQ-042 rst pulse in CMP -> no res_valid, valid bits cleared, subsequent search of prior rule -> res_hit=0.
